// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, result payload, op classifiers.
package md_sched_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WIDTH_MDOP = 3;

    typedef enum logic [WIDTH_MDOP-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } md_res_t;

    // Ops that occupy the unit for a countdown and commit through the pending registers.
    function automatic logic md_is_arith(input logic [WIDTH_MDOP-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [WIDTH_MDOP-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_arith.sv
// Combinational mult/div datapath; an iterative unit can replace it behind the top-level countdown.
module md_sched_arith
    import md_sched_pkg::*;
(
    input  logic [WIDTH_MDOP-1:0] op_i,
    input  logic [XLEN-1:0]       a_i,
    input  logic [XLEN-1:0]       b_i,
    output md_res_t               res_c_o,
    output logic                  div0_c_o
);

    localparam int unsigned PW = 2 * XLEN;

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic signed [PW-1:0]   prod_s;
    logic [PW-1:0]          prod_u;

    assign a_s    = a_i;
    assign b_s    = b_i;
    assign prod_s = PW'(a_s) * PW'(b_s);
    assign prod_u = PW'(a_i) * PW'(b_i);

    always_comb begin
        res_c_o  = '0;
        div0_c_o = 1'b0;
        case (op_i)
            MD_MULT:  res_c_o = prod_s;
            MD_MULTU: res_c_o = prod_u;
            MD_DIV: begin
                if (b_i == '0) begin
                    div0_c_o = 1'b1;
                end else if (a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1) begin
                    // Overflow case: quotient wraps to the dividend, remainder is zero.
                    res_c_o.lo = a_i;
                    res_c_o.hi = '0;
                end else begin
                    res_c_o.lo = a_s / b_s;
                    res_c_o.hi = a_s % b_s;
                end
            end
            MD_DIVU: begin
                if (b_i == '0) begin
                    div0_c_o = 1'b1;
                end else begin
                    res_c_o.lo = a_i / b_i;
                    res_c_o.hi = a_i % b_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Mult/div sequencer: countdown-modelled latency, HI/LO commit, and ID stall request.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [WIDTH_MDOP-1:0] op_i,
    input  logic [XLEN-1:0]       src_a_i,
    input  logic [XLEN-1:0]       src_b_i,
    input  logic                  cancel_i,
    input  logic                  id_uses_md_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  stall_req_c_o,
    output logic [XLEN-1:0]       hi_o,
    output logic [XLEN-1:0]       lo_o
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    md_res_t          pend_q, pend_d;
    logic             pend_div0_q, pend_div0_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    md_res_t          res;
    logic             div0;

    md_sched_arith u_arith (
        .op_i     (op_i),
        .a_i      (src_a_i),
        .b_i      (src_b_i),
        .res_c_o  (res),
        .div0_c_o (div0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            pend_q      <= '0;
            pend_div0_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            pend_div0_q <= pend_div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Cancel dominates everything: it drops a same-cycle start and aborts a running op.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pend_d      = pend_q;
        pend_div0_d = pend_div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !cancel_i) begin
                    if (md_is_arith(op_i)) begin
                        pend_d      = res;
                        pend_div0_d = div0;
                        count_d     = md_is_div(op_i) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d     = ST_RUN;
                    end else if (op_i == MD_MTHI) begin
                        hi_d = src_a_i;
                    end else if (op_i == MD_MTLO) begin
                        lo_d = src_a_i;
                    end
                end
            end
            ST_RUN: begin
                if (cancel_i) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (count_q == CNT_W'(1)) begin
                    if (!pend_div0_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
        busy_d = (state_d == ST_RUN);
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign stall_req_c_o = id_uses_md_i & (busy_q | (start_i & md_is_arith(op_i)));

    a_no_start_in_run: assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == ST_RUN && start_i));

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes expected HI/LO commits, a monitor checks each done pulse.
module tb_md_sched;
    import md_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        cancel, id_uses_md;
    logic        busy, done, stall_req;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb[$];

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .op_i          (op),
        .src_a_i       (src_a),
        .src_b_i       (src_b),
        .cancel_i      (cancel),
        .id_uses_md_i  (id_uses_md),
        .busy_o        (busy),
        .done_o        (done),
        .stall_req_c_o (stall_req),
        .hi_o          (hi),
        .lo_o          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL done_unexpected: got hi=0x%0h lo=0x%0h expected no done", hi, lo);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if ({hi, lo} !== e) begin
                    n_bad++;
                    $display("FAIL commit: got hi=0x%0h lo=0x%0h expected hi=0x%0h lo=0x%0h",
                             hi, lo, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall);
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        chk("stall_on_start", 64'(stall_req), 64'(exp_stall));
        tick();
        start = 1'b0;
    endtask

    // Count busy cycles (bounded), checking stall each busy cycle, then check done/stall at the drop.
    task automatic run_and_count(input string name, input int exp_cycles);
        int n = 0;
        while (busy && n < 40) begin
            chk("stall_busy", 64'(stall_req), 64'(id_uses_md));
            tick();
            n++;
        end
        chk({name, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
        chk({name, "_done_pulse"}, 64'(done), 64'd1);
        chk({name, "_stall_drop"}, 64'(stall_req), 64'd0);
        tick();
        chk({name, "_done_clear"}, 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        cancel = 1'b0; id_uses_md = 1'b0;
        repeat (2) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        tick();

        // MULT -3*7 with an md instruction waiting in ID
        id_uses_md = 1'b1;
        sb.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
        issue(MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b1);
        run_and_count("mult", 5);
        chk("mult_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
        id_uses_md = 1'b0;

        sb.push_back({32'h00000001, 32'hFFFFFFFE});
        issue(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
        run_and_count("multu", 5);

        sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_and_count("div", 10);

        sb.push_back({32'h00000000, 32'h80000000});
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_and_count("div_ovf", 10);

        sb.push_back({32'h00000002, 32'h0000000E});
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
        run_and_count("divu", 10);

        // MTHI/MTLO: one-edge write, never busy, never stalls
        id_uses_md = 1'b1;
        issue(MD_MTHI, 32'h11, 32'h0, 1'b0);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_hi", 64'(hi), 64'h11);
        issue(MD_MTLO, 32'h22, 32'h0, 1'b0);
        chk("mtlo_lo", 64'(lo), 64'h22);
        chk("mtlo_hi_kept", 64'(hi), 64'h11);
        id_uses_md = 1'b0;

        // Divide by zero: full latency, done pulses, HI/LO unchanged
        sb.push_back({32'h00000011, 32'h00000022});
        issue(MD_DIVU, 32'd7, 32'd0, 1'b0);
        run_and_count("divu0", 10);

        // Cancel during the 4th busy cycle of a DIV
        issue(MD_DIV, 32'd100, 32'd3, 1'b0);
        repeat (3) tick();
        chk("cancel_pre_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        repeat (12) tick();
        chk("cancel_hilo", {hi, lo}, {32'h11, 32'h22});

        // Cancel in the start cycle drops the start
        cancel = 1'b1;
        issue(MD_MULT, 32'd3, 32'd4, 1'b0);
        cancel = 1'b0;
        chk("cancel_start_busy", 64'(busy), 64'd0);
        repeat (7) tick();
        chk("cancel_start_hilo", {hi, lo}, {32'h11, 32'h22});

        // Async reset during cycle 2 of a MULT
        issue(MD_MULT, 32'd3, 32'd4, 1'b0);
        tick();
        chk("prereset_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_hilo", {hi, lo}, 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("post_rst_hilo", {hi, lo}, 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
